// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: steps the mux key through every channel, samples each after its settle window
// and publishes a packed frame over valid/ready. Optional feature macro: MUX_SCAN_OVERRUN_EN.
module mux_scan_ctrl #(
  parameter int NR_KEY   = 4,
  parameter int KEY_LEN  = 2,
  parameter int DATA_LEN = 2,
  parameter int DIV      = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  output logic [KEY_LEN-1:0]           sel,
  input  logic [DATA_LEN-1:0]          mux_in,
  output logic [NR_KEY*DATA_LEN-1:0]   frame,
  output logic                         frame_valid,
  input  logic                         frame_ready,
  output logic                         busy,
  output logic                         overrun
);

  localparam int                 FRAME_W  = NR_KEY * DATA_LEN;
  localparam logic [31:0]        CNT_LAST = 32'(DIV);
  localparam logic [KEY_LEN-1:0] KEY_LAST = KEY_LEN'(NR_KEY - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [31:0]          r_cnt;
  logic [KEY_LEN-1:0]   r_sel;
  logic [FRAME_W-1:0]   r_shadow;
  logic [FRAME_W-1:0]   r_frame;
  logic [FRAME_W-1:0]   w_new_frame;
  logic                 r_frame_valid;
  logic                 w_hold_done;
  logic                 w_publish;
  logic                 w_xfer;
  logic                 w_busy;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: en is only looked at in IDLE and on the frame-end edge
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (en) begin
          w_state_nxt = ST_SCAN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (w_publish && !en) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_SCAN;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output decode from the state register
  always_comb begin
    w_busy = 1'b0;
    case (r_state)
      ST_SCAN: w_busy = 1'b1;
      ST_IDLE: w_busy = 1'b0;
      default: w_busy = 1'b0;
    endcase
  end

  assign w_hold_done = (r_state == ST_SCAN) && (r_cnt == CNT_LAST);
  assign w_publish   = w_hold_done && (r_sel == KEY_LAST);
  assign w_xfer      = r_frame_valid && frame_ready;

  // Settle counter and key sequencing
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= 32'd0;
      r_sel <= '0;
    end else if (r_state != ST_SCAN) begin
      r_cnt <= 32'd0;
      r_sel <= '0;
    end else if (w_hold_done) begin
      r_cnt <= 32'd0;
      if (r_sel == KEY_LAST) begin
        r_sel <= '0;
      end else begin
        r_sel <= r_sel + KEY_LEN'(1);
      end
    end else begin
      r_cnt <= r_cnt + 32'd1;
    end
  end

  // Per-channel capture at the end of each hold window
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shadow <= '0;
    end else if (w_hold_done) begin
      for (int k = 0; k < NR_KEY; k++) begin
        if (r_sel == KEY_LEN'(k)) begin
          r_shadow[k*DATA_LEN +: DATA_LEN] <= mux_in;
        end
      end
    end else begin
      r_shadow <= r_shadow;
    end
  end

  // The last channel bypasses the shadow so the frame is complete on the capture edge
  always_comb begin
    w_new_frame                            = r_shadow;
    w_new_frame[FRAME_W-1 -: DATA_LEN]     = mux_in;
  end

  // Frame publication and downstream handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frame       <= '0;
      r_frame_valid <= 1'b0;
    end else if (w_publish) begin
      if (!r_frame_valid || w_xfer) begin
        r_frame       <= w_new_frame;
        r_frame_valid <= 1'b1;
      end else begin
`ifdef MUX_SCAN_OVERRUN_EN
        r_frame       <= r_frame;
`else
        r_frame       <= w_new_frame;
`endif
        r_frame_valid <= 1'b1;
      end
    end else if (w_xfer) begin
      r_frame_valid <= 1'b0;
    end else begin
      r_frame_valid <= r_frame_valid;
    end
  end

`ifdef MUX_SCAN_OVERRUN_EN
  logic r_overrun;

  // Sticky overrun: a frame finished while the previous one was still pending
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overrun <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      r_overrun <= 1'b0;
    end else if (w_publish && r_frame_valid && !w_xfer) begin
      r_overrun <= 1'b1;
    end else begin
      r_overrun <= r_overrun;
    end
  end

  assign overrun = r_overrun;
`else
  assign overrun = 1'b0;
`endif

  assign sel         = r_sel;
  assign frame       = r_frame;
  assign frame_valid = r_frame_valid;
  assign busy        = w_busy;

endmodule
